// File: rtl/boss_sprite_ctrl.sv
// Boss sprite controller: hit points, horizontal patrol, explosion/dead/respawn sequencing and boss pixel layer.
// Optional hit flash: define BOSS_HIT_FLASH_EN.
//
// state      | meaning
// ST_ALIVE   | patrolling, takes hits, drawn from the sprite bitmap
// ST_EXPLODE | frozen, steps through BOOM_FRAMES explosion bitmaps on tick
// ST_DEAD    | not drawn, waits for revive or the respawn timer
module boss_sprite_ctrl #(
    parameter int          SPR_W         = 128,
    parameter int          SPR_H         = 128,
    parameter int          SCR_W         = 640,
    parameter int          X0            = 256,
    parameter int          Y0            = 0,
    parameter int          SPEED         = 2,
    parameter int          HP_MAX        = 8,
    parameter int          HP_W          = 4,
    parameter int          BOOM_FRAMES   = 4,
    parameter int          FRAME_TICKS   = 8,
    parameter int          RESPAWN_TICKS = 0,
    parameter logic [11:0] TRANSP        = 12'hFFF,
    parameter int          ADDR_W        = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              hit,
    input  logic              revive,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_rgb,
    output logic [9:0]        boss_x,
    output logic [9:0]        boss_y,
    output logic [11:0]       rgb,
    output logic              pixel_en,
    output logic              alive,
    output logic [HP_W-1:0]   hp,
    output logic              killed
);
    typedef enum logic [1:0] {ST_ALIVE, ST_EXPLODE, ST_DEAD} state_t;

    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int FW = $clog2(BOOM_FRAMES + 1);
    localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [10:0]       X_MAX      = 11'(SCR_W - SPR_W);
    localparam logic [10:0]       STEP       = 11'(SPEED);
    localparam logic [TW-1:0]     TICK_LAST  = TW'(FRAME_TICKS - 1);
    localparam logic [FW-1:0]     FRAME_LAST = FW'(BOOM_FRAMES - 1);
    localparam logic [RW-1:0]     RESP_LAST  = RW'(RESPAWN_TICKS - 1);
    localparam logic [HP_W-1:0]   HP_FULL    = HP_W'(HP_MAX);
    localparam logic [ADDR_W-1:0] FRAME_SZ   = ADDR_W'(SPR_W * SPR_H);

    state_t          state;
    logic            dir_left;
    logic [TW-1:0]   tick_cnt;
    logic [FW-1:0]   frame_idx;
    logic [RW-1:0]   resp_cnt;
    logic [10:0]     x_right;
    logic [9:0]      x_left;
    logic            respawn;

    assign x_right = {1'b0, boss_x} + STEP;
    assign x_left  = boss_x - 10'(SPEED);
    assign boss_y  = 10'(Y0);
    assign respawn = revive || (RESPAWN_TICKS > 0 && tick && resp_cnt == RESP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ALIVE;
            boss_x    <= 10'(X0);
            dir_left  <= 1'b0;
            hp        <= HP_FULL;
            tick_cnt  <= '0;
            frame_idx <= '0;
            resp_cnt  <= '0;
            alive     <= 1'b1;
            killed    <= 1'b0;
        end else begin
            killed <= 1'b0;
            case (state)
                ST_ALIVE: begin
                    if (tick) begin
                        if (dir_left) begin
                            if ({1'b0, boss_x} <= STEP) begin
                                boss_x   <= '0;
                                dir_left <= 1'b0;
                            end else begin
                                boss_x <= x_left;
                            end
                        end else if (x_right >= X_MAX) begin
                            boss_x   <= X_MAX[9:0];
                            dir_left <= 1'b1;
                        end else begin
                            boss_x <= x_right[9:0];
                        end
                    end
                    if (hit) begin
                        if (hp > HP_W'(1)) begin
                            hp <= hp - HP_W'(1);
                        end else begin
                            hp        <= '0;
                            killed    <= 1'b1;
                            alive     <= 1'b0;
                            state     <= ST_EXPLODE;
                            tick_cnt  <= '0;
                            frame_idx <= '0;
                        end
                    end
                end
                ST_EXPLODE: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            frame_idx <= frame_idx + FW'(1);
                            if (frame_idx == FRAME_LAST) begin
                                state    <= ST_DEAD;
                                resp_cnt <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                ST_DEAD: begin
                    // revive takes priority over a coincident tick, so no motion on the respawn edge
                    if (respawn) begin
                        state     <= ST_ALIVE;
                        alive     <= 1'b1;
                        boss_x    <= 10'(X0);
                        dir_left  <= 1'b0;
                        hp        <= HP_FULL;
                        tick_cnt  <= '0;
                        frame_idx <= '0;
                    end else if (RESPAWN_TICKS > 0 && tick) begin
                        resp_cnt <= resp_cnt + RW'(1);
                    end
                end
                default: state <= ST_ALIVE;
            endcase
        end
    end

    logic flash_on;
`ifdef BOSS_HIT_FLASH_EN
    localparam logic [2:0] FLASH_TICKS = 3'd4;
    logic [2:0] flash_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt <= '0;
        end else if (state == ST_ALIVE && hit) begin
            flash_cnt <= (hp > HP_W'(1)) ? FLASH_TICKS : 3'd0;
        end else if (tick && flash_cnt != 3'd0) begin
            flash_cnt <= flash_cnt - 3'd1;
        end
    end
    assign flash_on = (flash_cnt != 3'd0) && (state == ST_ALIVE);
`else
    assign flash_on = 1'b0;
`endif

    logic [9:0]  col, row;
    logic [10:0] x_end, y_end;
    logic        in_box, in_box_d, visible_d, inv_d;

    assign col    = x - boss_x;
    assign row    = y - boss_y;
    assign x_end  = {1'b0, boss_x} + 11'(SPR_W);
    assign y_end  = {1'b0, boss_y} + 11'(SPR_H);
    assign in_box = (x >= boss_x) && ({1'b0, x} < x_end) && (y >= boss_y) && ({1'b0, y} < y_end);

    // explosion bitmaps follow the sprite bitmap in the ROM, one SPR_W*SPR_H block per frame
    assign rom_addr = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col)
                    + ((state == ST_EXPLODE) ? (ADDR_W'(frame_idx) * FRAME_SZ + FRAME_SZ) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_box_d  <= 1'b0;
            visible_d <= 1'b0;
            inv_d     <= 1'b0;
        end else begin
            in_box_d  <= in_box;
            visible_d <= (state != ST_DEAD);
            inv_d     <= flash_on;
        end
    end

    assign pixel_en = in_box_d & visible_d & (rom_rgb != TRANSP);
    assign rgb      = !pixel_en ? 12'h000 : (inv_d ? ~rom_rgb : rom_rgb);
endmodule

// File: tb/tb_boss_sprite_ctrl.sv
// Self-checking bench for boss_sprite_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_boss_sprite_ctrl;
    localparam int SPR_W = 128, SPR_H = 128, SCR_W = 640, X0 = 256, Y0 = 0, SPEED = 2;
    localparam int HP_MAX = 8, HP_W = 4, BOOM_FRAMES = 4, FRAME_TICKS = 8, RESPAWN_TICKS = 0;
    localparam int ADDR_W = 18;
    localparam logic [11:0] TRANSP = 12'hFFF;
    localparam int HI = SCR_W - SPR_W;

    logic clk = 0, rst = 1, tick = 0, hit = 0, revive = 0;
    logic [9:0] x = 0, y = 0;
    logic [11:0] rom_rgb = 0, rom_val = 0;
    logic [ADDR_W-1:0] rom_addr;
    logic [9:0] boss_x, boss_y;
    logic [11:0] rgb;
    logic pixel_en, alive, killed;
    logic [HP_W-1:0] hp;

    int n_tests = 0, n_fail = 0;

    boss_sprite_ctrl #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SCR_W(SCR_W), .X0(X0), .Y0(Y0), .SPEED(SPEED),
        .HP_MAX(HP_MAX), .HP_W(HP_W), .BOOM_FRAMES(BOOM_FRAMES), .FRAME_TICKS(FRAME_TICKS),
        .RESPAWN_TICKS(RESPAWN_TICKS), .TRANSP(TRANSP), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .x(x), .y(y), .hit(hit), .revive(revive),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb), .boss_x(boss_x), .boss_y(boss_y),
        .rgb(rgb), .pixel_en(pixel_en), .alive(alive), .hp(hp), .killed(killed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_rgb <= rom_val;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: phase 0 = alive, 1 = exploding, 2 = dead; explosion tracked as total ticks elapsed
    int m_phase, m_x, m_dir, m_hp, m_boom, m_dead, m_flash, nx;
    bit m_killed, m_box_d, m_vis_d, m_inv_d;

    function automatic bit box_hit(int px, int py, int bx);
        return px >= bx && px < bx + SPR_W && py >= Y0 && py < Y0 + SPR_H;
    endfunction

    function automatic int exp_addr();
        int a;
        a = ((int'(y) - Y0) & 1023) * SPR_W + ((int'(x) - m_x) & 1023);
        if (m_phase == 1) a += (m_boom / FRAME_TICKS + 1) * SPR_W * SPR_H;
        return a & ((1 << ADDR_W) - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_x <= X0; m_dir <= 1; m_hp <= HP_MAX; m_boom <= 0; m_dead <= 0;
            m_flash <= 0; m_killed <= 0; m_box_d <= 0; m_vis_d <= 0; m_inv_d <= 0;
        end else begin
            m_box_d  <= box_hit(x, y, m_x);
            m_vis_d  <= (m_phase != 2);
            m_inv_d  <= (m_flash > 0) && (m_phase == 0);
            m_killed <= 0;
`ifdef BOSS_HIT_FLASH_EN
            if (hit && m_phase == 0) m_flash <= (m_hp > 1) ? 4 : 0;
            else if (tick && m_flash > 0) m_flash <= m_flash - 1;
`endif
            if (m_phase == 0) begin
                if (tick) begin
                    nx = m_x + m_dir * SPEED;
                    if (nx >= HI) begin m_x <= HI; m_dir <= -1; end
                    else if (nx <= 0) begin m_x <= 0; m_dir <= 1; end
                    else m_x <= nx;
                end
                if (hit) begin
                    if (m_hp > 1) m_hp <= m_hp - 1;
                    else begin m_hp <= 0; m_killed <= 1; m_phase <= 1; m_boom <= 0; end
                end
            end else if (m_phase == 1) begin
                if (tick) begin
                    m_boom <= m_boom + 1;
                    if (m_boom + 1 == BOOM_FRAMES * FRAME_TICKS) begin m_phase <= 2; m_dead <= 0; end
                end
            end else begin
                if (revive || (RESPAWN_TICKS > 0 && tick && m_dead + 1 == RESPAWN_TICKS)) begin
                    m_phase <= 0; m_x <= X0; m_dir <= 1; m_hp <= HP_MAX;
                end else if (RESPAWN_TICKS > 0 && tick) m_dead <= m_dead + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e_rgb;
        bit e_en;
        if (!rst) begin
            e_en  = m_box_d && m_vis_d && (rom_rgb != TRANSP);
            e_rgb = !e_en ? 12'h000 : (m_inv_d ? ~rom_rgb : rom_rgb);
            chk("boss_x", int'(boss_x), m_x);
            chk("boss_y", int'(boss_y), Y0);
            chk("hp", int'(hp), m_hp);
            chk("alive", int'(alive), int'(m_phase == 0));
            chk("killed", int'(killed), int'(m_killed));
            chk("rom_addr", int'(rom_addr), exp_addr());
            chk("pixel_en", int'(pixel_en), int'(e_en));
            chk("rgb", int'(rgb), int'(e_rgb));
            chk("x_range", int'(boss_x <= 10'(HI)), 1);
        end
    end

    task automatic cyc(input bit t, input bit h, input bit r);
        @(posedge clk); #1;
        tick = t; hit = h; revive = r;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_x", boss_x, 256); chk("rst_hp", hp, 8); chk("rst_alive", alive, 1);
        chk("rst_killed", killed, 0); chk("rst_pen", pixel_en, 0); chk("rst_rgb", rgb, 0);

        // patrol: reaches 512 after 128 ticks, then heads back left
        for (int i = 0; i < 200; i++) begin
            cyc(1, 0, 0);
            if (i == 128) chk("x_at_128", boss_x, 512);
        end
        cyc(0, 0, 0);
        chk("x_at_200", boss_x, 368);

        // pixel path at (boss_x+5, boss_y+3)
        x = 373; y = 3; rom_val = 12'h0F0;
        #1 chk("addr_pix", rom_addr, 389);
        cyc(0, 0, 0);
        chk("pix_en", pixel_en, 1); chk("pix_rgb", rgb, 12'h0F0);
        rom_val = 12'hFFF;
        cyc(0, 0, 0);
        chk("transp_en", pixel_en, 0); chk("transp_rgb", rgb, 0);
        x = 0; rom_val = 12'h0F0;
        cyc(0, 0, 0);
        chk("outside_en", pixel_en, 0);

        // eight hits, the third coincident with a tick
        for (int i = 1; i <= 8; i++) begin
            cyc(i == 3, 1, 0);
            cyc(0, 0, 0);
            chk("hp_hit", hp, 8 - i);
        end
        chk("killed_pulse", killed, 1); chk("dead_alive", alive, 0);

        // explosion: frame base steps by 16384 every 8 ticks
        x = 10'(m_x); y = 0; rom_val = 12'h0F0;
        #1 chk("boom_f0", rom_addr, 16384);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) cyc(1, 1, 1); else cyc(1, 0, 0);
            if (i == 1) chk("killed_once", killed, 0);
            if (i == 8) chk("boom_f1", rom_addr, 32768);
            if (i == 31) chk("boom_f3", rom_addr, 65536);
        end
        cyc(0, 0, 0);
        chk("dead_addr", rom_addr, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("dead_pen", pixel_en, 0); chk("dead_hp", hp, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        chk("revive_x", boss_x, 256); chk("revive_hp", hp, 8); chk("revive_alive", alive, 1);

        // hit flash (inverted colour only when the flash option is built in)
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        x = 10'(m_x + 60); y = 3; rom_val = 12'h0F0;
        cyc(0, 0, 0);
`ifdef BOSS_HIT_FLASH_EN
        chk("flash_rgb", rgb, 12'hF0F);
`else
        chk("noflash_rgb", rgb, 12'h0F0);
`endif
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0);
            x = 10'(m_x + 60);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("after_flash_rgb", rgb, 12'h0F0);

        // kill again, then async reset in the middle of the explosion
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 0);
            cyc(0, 0, 0);
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("pre_rst_alive", alive, 0);
        #3 rst = 1;
        #1 chk("arst_hp", hp, 8); chk("arst_alive", alive, 1); chk("arst_x", boss_x, 256);
        chk("arst_pen", pixel_en, 0);
        @(posedge clk); #1 rst = 0;
        repeat (4) cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("post_rst_x", boss_x, 264);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/boss_sprite_ctrl.md
# boss_sprite_ctrl

Parametrised boss controller for the VGA shooter. It tracks hit points and horizontal patrol motion, and sequences a multi-frame explosion, a dead state and respawn. It also produces the per-pixel address, colour and enable for the boss layer of the pixel mixer. Sprite and explosion bitmaps live in one external 1-cycle-latency ROM; this block only addresses it and qualifies its data.

## Interface
Parameters:
- SPR_W, 128: sprite width in pixels (power of two).
- SPR_H, 128: sprite height in pixels.
- SCR_W, 640: screen width; patrol range is 0..SCR_W-SPR_W.
- X0, 256: spawn x.
- Y0, 0: spawn y (fixed; no vertical motion).
- SPEED, 2: pixels moved per tick.
- HP_MAX, 8: hit points at spawn (≥1).
- HP_W, 4: hp width.
- BOOM_FRAMES, 4: explosion frames.
- FRAME_TICKS, 8: ticks per explosion frame.
- RESPAWN_TICKS, 0: ticks in DEAD before auto-revive; 0 disables auto-revive.
- TRANSP, 12'hFFF: transparent colour key.
- ADDR_W, 18: ROM address width, ≥ clog2(SPR_W*SPR_H*(BOOM_FRAMES+1)).

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: asynchronous, active-high reset.
- tick, in, 1: single-cycle motion/animation enable, synchronous to clk.
- x, y, in, 10 each: current scan coordinates.
- hit, in, 1: single-cycle hit pulse from collision logic.
- revive, in, 1: single-cycle respawn request.
- rom_addr, out, ADDR_W: combinational ROM address.
- rom_rgb, in, 12: ROM data, valid 1 clk after rom_addr.
- boss_x, boss_y, out, 10 each: sprite top-left corner.
- rgb, out, 12: boss pixel colour.
- pixel_en, out, 1: boss pixel is opaque this cycle.
- alive, out, 1: high in ALIVE.
- hp, out, HP_W: remaining hit points.
- killed, out, 1: one-cycle pulse on the lethal hit.

## Operation
States: ALIVE, EXPLODE, DEAD. Reset values:
- State ALIVE.
- boss_x=X0, boss_y=Y0, hp=HP_MAX.
- Direction right; all counters 0.
- rgb=0, pixel_en=0, killed=0, alive=1.

ALIVE:
- On tick, move x by SPEED in the current direction.
- Moving right with x+SPEED ≥ SCR_W-SPR_W: x := SCR_W-SPR_W and the direction flips to left.
- Moving left with x ≤ SPEED: x := 0 and the direction flips to right.
- On hit with hp>1: hp decrements.
- On hit with hp==1: hp := 0, killed pulses, next state EXPLODE, frame and tick counters clear.
- hit and tick in the same cycle: both take effect.

EXPLODE:
- Position is frozen.
- On tick the tick counter increments; at FRAME_TICKS-1 it wraps to 0 and the frame index increments.
- When the frame index reaches BOOM_FRAMES, the block enters DEAD and the respawn counter clears.
- hit and revive are ignored.

DEAD:
- Nothing is drawn.
- revive leads to ALIVE with spawn position, hp=HP_MAX and direction right.
- If RESPAWN_TICKS>0, the respawn counter counts ticks; reaching RESPAWN_TICKS performs the same revive.
- revive and tick in the same cycle: revive wins.
- hit is ignored.

Pixel path:
- col=x-boss_x and row=y-boss_y, 10 bits with wrap.
- in_box = x≥boss_x, x<boss_x+SPR_W, y≥boss_y, y<boss_y+SPR_H.
- rom_addr = row*SPR_W + col, plus (frame+1)*SPR_W*SPR_H in EXPLODE.
- in_box, the visible flag (state≠DEAD) and the inversion flag are registered one stage to align with rom_rgb.
- pixel_en = in_box_d & visible_d & (rom_rgb≠TRANSP).
- rgb = rom_rgb when pixel_en, otherwise 0.

## Timing
- Latency from x,y to rgb/pixel_en is 1 clk.
- State, position and hp update on the clk edge where tick/hit/revive is sampled high.
- killed is high for the single cycle after the lethal hit edge, coincident with the first cycle of EXPLODE.
- A position change mid-frame is legal. The registered pixel flags may use the pre-update position for 1 clk; this is accepted.
- rst mid-explosion or mid-respawn returns all state to reset values immediately.

## Configuration
Macro: BOSS_HIT_FLASH_EN.

Defined:
- A non-lethal hit loads a flash counter with FLASH_TICKS (local constant 4).
- The counter decrements on tick.
- While it is nonzero and the state is ALIVE, rgb = ~rom_rgb for opaque pixels; pixel_en is unchanged.
- A new hit reloads the counter.
- The counter clears on entry to EXPLODE.

Undefined:
- No flash counter exists; rgb is always rom_rgb when opaque.

## Test plan
- Reset, then 200 ticks with SCR_W=640, SPR_W=128, X0=256, SPEED=2 -> x reaches 512, reverses, returns toward 0; never leaves 0..512.
- 8 hit pulses with HP_MAX=8 -> hp 7..1 on hits 1–7; 8th gives hp=0, one killed pulse, alive=0, state EXPLODE.
- In EXPLODE with default parameters, 32 ticks -> frame index 0..3, rom_addr base steps by 16384 per frame; DEAD after tick 32 and pixel_en stays 0.
- DEAD with RESPAWN_TICKS=0, revive asserted together with tick -> ALIVE, x=256, hp=8; hit during EXPLODE/DEAD leaves hp=0.
- Scan at x=boss_x+5, y=boss_y+3 with ROM returning 12'h0F0 -> rgb=0F0, pixel_en=1 one clk later; ROM returning FFF -> pixel_en=0, rgb=0.
- With BOSS_HIT_FLASH_EN, one hit then ROM 12'h0F0 -> rgb=F0F for 4 ticks, then 0F0.
